// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one result bit per clock, LSB first, IDLE -> RUN -> DONE.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the Sub port).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             Sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   logic             sum_bit_s;
   logic             carry_nxt_s;
   logic [WIDTH:0]   res_cat_s;
   logic [WIDTH-1:0] res_nxt_s;
   logic [WIDTH-1:0] addend_s;
   logic             cin_s;
   logic             last_s;

   // Per-bit full adder and the result shifted down by one with the new bit at the MSB.
   always_comb begin
      sum_bit_s   = a_r[0] ^ b_r[0] ^ carry_r;
      carry_nxt_s = maj3(a_r[0], b_r[0], carry_r);
      res_cat_s   = {sum_bit_s, res_r};
      res_nxt_s   = res_cat_s[WIDTH:1];
      last_s      = (cnt_r == CW'(WIDTH - 1));
   end

   // Operand selection at start: subtraction adds ~B with a forced carry-in of 1.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      if (Sub) begin
         addend_s = ~B;
         cin_s    = 1'b1;
      end else begin
         addend_s = B;
         cin_s    = Cin;
      end
`else
      addend_s = B;
      cin_s    = Cin;
`endif
   end

   // Control FSM, datapath shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= A;
                  b_r     <= addend_s;
                  carry_r <= cin_s;
                  cnt_r   <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               a_r     <= a_r >> 1;
               b_r     <= b_r >> 1;
               carry_r <= carry_nxt_s;
               res_r   <= res_nxt_s;
               cnt_r   <= cnt_r + CW'(1);
               if (last_s) begin
                  sum_r   <= res_nxt_s;
                  cout_r  <= carry_nxt_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign Sum  = sum_r;
   assign Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vectors, mid-run start/reset, and WIDTH=2 exhaustive.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       start2;
   logic [1:0] a2, b2;
   logic       cin2;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;
   logic       sub8;
   int         vectors;
   int         fails;
   logic [7:0] prev_sum;
   int         done_cnt;
   logic [7:0] got_sum;
   logic       got_cout;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .Sub(sub8),
`endif
      .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
      .Sub(1'b0),
`endif
      .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start an 8-bit add, scramble inputs after the start edge, check busy/hold/done timing.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
      a8 = a; b8 = b; cin8 = c; start = 1'b1;
      step();
      start = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("run_busy_%0d", k), 32'(busy8), 32'd1);
         chk($sformatf("run_done_%0d", k), 32'(done8), 32'd0);
         chk($sformatf("run_hold_%0d", k), 32'(sum8), 32'(prev_sum));
         step();
      end
      chk("done_busy", 32'(busy8), 32'd0);
      chk("done_pulse", 32'(done8), 32'd1);
      chk("sum", 32'(sum8), 32'(es));
      chk("cout", 32'(cout8), 32'(ec));
      step();
      chk("done_clear", 32'(done8), 32'd0);
      prev_sum = es;
   endtask

   initial begin
      vectors = 0; fails = 0; prev_sum = 8'h00;
      rst_n = 1'b0; start = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
      start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
      #22;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout", 32'(cout8), 32'd0);
      rst_n = 1'b1;

      run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
      run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

      // start pulsed mid-run must be ignored
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      a8 = 8'hFF; b8 = 8'h77; cin8 = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      done_cnt = 0; got_sum = 8'h00; got_cout = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done8) begin
            done_cnt++;
            got_sum = sum8;
            got_cout = cout8;
         end
         step();
      end
      chk("ign_done_count", 32'(done_cnt), 32'd1);
      chk("ign_sum", 32'(got_sum), 32'h30);
      chk("ign_cout", 32'(got_cout), 32'd0);
      chk("ign_idle_busy", 32'(busy8), 32'd0);
      prev_sum = 8'h30;

      // reset in the middle of RUN aborts with no done pulse
      a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("pre_rst_busy", 32'(busy8), 32'd1);
      chk("pre_rst_sum", 32'(sum8), 32'h30);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_sum", 32'(sum8), 32'd0);
      chk("abort_cout", 32'(cout8), 32'd0);
      step();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (done8) done_cnt++;
         step();
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      prev_sum = 8'h00;
      run8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      sub8 = 1'b1;
      run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
      run8(8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
      sub8 = 1'b0;
      run8(8'h05, 8'h07, 1'b1, 8'h0D, 1'b0);
`endif

      // WIDTH=2 exhaustive, back-to-back at the minimum restart spacing
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 2; c++) begin
               a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
               step();
               start2 = 1'b0;
               a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
               chk("w2_busy", 32'(busy2), 32'd1);
               step();
               chk("w2_busy2", 32'(busy2), 32'd1);
               step();
               chk("w2_done", 32'(done2), 32'd1);
               chk($sformatf("w2_%0d_%0d_%0d", a, b, c), 32'({cout2, sum2}), 32'(a + b + c));
               step();
               chk("w2_done_clear", 32'(done2), 32'd0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  augend; sampled with start.
REQ-006 Port: B  input  WIDTH  addend; sampled with start.
REQ-007 Port: Cin  input  1  carry-in; sampled with start.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse; Sum/Cout are valid.
REQ-010 Port: Sum  output  WIDTH  registered result.
REQ-011 Port: Cout  output  1  registered carry-out of the MSB.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: on an edge with start=1, the block SHALL latch A, B into operand shift registers, load the carry flop with Cin, clear the bit counter, and go to RUN.
REQ-014 RUN: each edge SHALL compute one result bit LSB-first as a^b^c, update carry to majority(a,b,c), shift operands right, and increment the counter.
REQ-015 After exactly WIDTH RUN edges, the block SHALL load Sum with the assembled result and Cout with the final carry, and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-017 Latency: for start sampled at edge N, done SHALL be high during the cycle following edge N+WIDTH, and the block SHALL accept the next start at edge N+WIDTH+2.
REQ-018 start during RUN or DONE SHALL be ignored, with no effect on operands, counter, or outputs.
REQ-019 Sum and Cout SHALL hold the previous result during RUN and SHALL change only on the RUN-to-DONE edge.
REQ-020 Changes on A, B, or Cin after the start edge SHALL NOT affect the result in progress.
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 done SHALL be 1 exactly in DONE.
REQ-023 Arithmetic: {Cout,Sum} SHALL equal A+B+Cin modulo 2^(WIDTH+1).
REQ-024 WIDTH=1 SHALL work: one RUN cycle, then DONE.
REQ-025 The counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, and clear Sum, Cout, busy, done, carry, counter, and operand registers to 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation, with no done pulse.
REQ-028 After reset deasserts, a start on the first active edge SHALL be accepted.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN:
- When defined, the block SHALL add port Sub (input, 1 bit, sampled with start).
- Sub=1 SHALL latch ~B as the addend and force the initial carry to 1, ignoring Cin, so that Sum=A-B mod 2^WIDTH and Cout=1 iff A>=B unsigned.
- Sub=0 SHALL behave exactly as the plain adder.
REQ-030 When SERIAL_ADDER_SUB_EN is undefined, the Sub port SHALL NOT exist, and the behaviour SHALL be the plain adder of REQ-023.

Verification (WIDTH=8 unless stated)
REQ-031 A=0x00, B=0x00, Cin=0, start at edge 0 -> busy on edges 1..8, done in cycle after edge 8, Sum=0x00, Cout=0.
REQ-032 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1.
REQ-033 A=0xA5, B=0x5A, Cin=1 -> Sum=0x00, Cout=1.
REQ-034 Start A=0x10, B=0x20; at RUN cycle 3 pulse start with A=0xFF and change A/B -> result Sum=0x30, Cout=0, exactly one done pulse.
REQ-035 Start an operation, drop rst_n at RUN cycle 4 -> all outputs 0 immediately, no done pulse; new start after release with A=0x03, B=0x04 -> Sum=0x07.
REQ-036 WIDTH=2 exhaustive over all A, B, Cin -> {Cout,Sum}=A+B+Cin; with SERIAL_ADDER_SUB_EN, WIDTH=8, A=0x05, B=0x07, Sub=1 -> Sum=0xFE, Cout=0.
